// File: rtl/step_dir_decoder_pkg.sv
// Shared definitions for the step/dir generator and decoder pair.
// Holds the 8-bit command format fields, the default window length and
// the internal net-accumulator range, plus helpers that pack a signed
// window count into the command format.
package step_dir_decoder_pkg;

  // Command format: bit 7 = direction (1 = negative), bits 6:0 = magnitude.
  localparam int unsigned DIR_BIT = 7;
  localparam int unsigned MAG_MSB = 6;
  localparam int unsigned MAG_MAX = 127;

  // 10 ms window at 20 MHz.
  localparam int unsigned CLK_PER_WIN_DEF = 200000;

  // Window accumulator saturates at +/-255 internally.
  localparam int unsigned NET_W = 9;
  localparam logic signed [NET_W-1:0] NET_MAX = NET_W'(255);
  localparam logic signed [NET_W-1:0] NET_MIN = -NET_MAX;
  localparam logic signed [NET_W-1:0] NET_ONE = NET_W'(1);

  function automatic logic [NET_W-1:0] abs_net(input logic signed [NET_W-1:0] net);
    return net[NET_W-1] ? NET_W'(-net) : NET_W'(net);
  endfunction

  function automatic logic mag_over(input logic signed [NET_W-1:0] net);
    return abs_net(net) > NET_W'(MAG_MAX);
  endfunction

  function automatic logic [7:0] pack_cmd(input logic signed [NET_W-1:0] net);
    logic [NET_W-1:0] mag;
    logic [7:0]       cmd;
    mag = abs_net(net);
    cmd = '0;
    cmd[DIR_BIT] = net[NET_W-1];
    cmd[MAG_MSB:0] = (mag > NET_W'(MAG_MAX)) ? 7'(MAG_MAX) : mag[MAG_MSB:0];
    return cmd;
  endfunction

endpackage

// File: rtl/step_qualifier.sv
// Step qualifier: synchronizes the asynchronous pulse/dir lines and
// filters out short high phases.
//   clk, rst  : system clock, synchronous active-high reset
//   pulse, dir: asynchronous step and direction inputs
//   step      : one-cycle strobe, one per qualified high phase
//   step_dir  : synchronized direction valid alongside step (1 = negative)
module step_qualifier
  import step_dir_decoder_pkg::*;
#(
  parameter int unsigned MIN_HIGH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  input  logic dir,
  output logic step,
  output logic step_dir
);

  localparam int unsigned HW = ($clog2(MIN_HIGH + 1) < 3) ? 3 : $clog2(MIN_HIGH + 1);

  logic [1:0]    p_sync;
  logic [1:0]    d_sync;
  logic [HW-1:0] hcnt;
  logic          ps;

  assign ps = p_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_sync <= '0;
      d_sync <= '0;
      hcnt   <= '0;
    end else begin
      p_sync <= {p_sync[0], pulse};
      d_sync <= {d_sync[0], dir};
      // hcnt parks at MIN_HIGH so a long high phase never re-hits the
      // qualifying value and yields exactly one step.
      if (!ps)
        hcnt <= '0;
      else if (hcnt != HW'(MIN_HIGH))
        hcnt <= hcnt + HW'(1);
    end
  end

  always_comb begin
    step     = ps && (hcnt == HW'(MIN_HIGH - 1));
    step_dir = d_sync[1];
  end

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir decoder: counts qualified steps per fixed window and reports the
// net count in the generator's 8-bit command format, plus a running
// signed position.
//   clk, rst : system clock, synchronous active-high reset
//   pulse,dir: asynchronous step / direction (dir = 1 is negative)
//   start    : restart the window (clears window counter and net)
//   ack      : host consumed N (one-cycle strobe)
//   N        : last window result {sign, saturated magnitude}
//   valid    : N holds unread data
//   ovf      : last window magnitude exceeded 127
//   lost     : sticky, a result was overwritten while unread
//   pos      : signed running position, wraps at POS_W
module step_dir_decoder
  import step_dir_decoder_pkg::*;
#(
  parameter int unsigned CLK_PER_WIN = CLK_PER_WIN_DEF,
  parameter int unsigned MIN_HIGH    = 4,
  parameter int unsigned POS_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pulse,
  input  logic                    dir,
  input  logic                    start,
  input  logic                    ack,
  output logic [7:0]              N,
  output logic                    valid,
  output logic                    ovf,
  output logic                    lost,
  output logic signed [POS_W-1:0] pos
);

  localparam int unsigned WCW = (CLK_PER_WIN > 1) ? $clog2(CLK_PER_WIN) : 1;

  logic                    step;
  logic                    step_dir;
  logic [WCW-1:0]          wcnt;
  logic signed [NET_W-1:0] net;
  logic signed [NET_W-1:0] net_nxt;
  logic signed [NET_W-1:0] close_val;
  logic                    close;

  step_qualifier #(
    .MIN_HIGH (MIN_HIGH)
  ) u_qual (
    .clk      (clk),
    .rst      (rst),
    .pulse    (pulse),
    .dir      (dir),
    .step     (step),
    .step_dir (step_dir)
  );

  always_comb begin
    net_nxt = net;
    if (step) begin
      if (!step_dir && net != NET_MAX)
        net_nxt = net + NET_ONE;
      else if (step_dir && net != NET_MIN)
        net_nxt = net - NET_ONE;
    end
    close     = (wcnt == WCW'(CLK_PER_WIN - 1));
    // A step coinciding with start is dropped from the window; otherwise a
    // step on the closing cycle belongs to the closing window.
    close_val = start ? net : net_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      net   <= '0;
      N     <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      lost  <= 1'b0;
      pos   <= '0;
    end else begin
      if (start || close)
        wcnt <= '0;
      else
        wcnt <= wcnt + WCW'(1);

      if (start || close)
        net <= '0;
      else
        net <= net_nxt;

      // Close takes priority over ack: new data is valid, and an ack in the
      // same cycle only suppresses the overwrite flag.
      if (close) begin
        N     <= pack_cmd(close_val);
        ovf   <= mag_over(close_val);
        valid <= 1'b1;
        lost  <= ~ack & (lost | valid);
      end else if (ack) begin
        valid <= 1'b0;
        lost  <= 1'b0;
      end

      if (step)
        pos <= step_dir ? pos - POS_W'(1) : pos + POS_W'(1);
    end
  end

endmodule

// File: tb/tb_step_dir_decoder.sv
module tb_step_dir_decoder;

  localparam int unsigned CPW = 1000;
  localparam int unsigned MH  = 4;

  logic clk = 1'b0;
  logic rst, pulse, dir, start, ack;
  logic [7:0]         N,  N4;
  logic               valid, ovf, lost, valid4, ovf4, lost4;
  logic signed [15:0] pos;
  logic signed [3:0]  pos4;

  step_dir_decoder #(.CLK_PER_WIN(CPW), .MIN_HIGH(MH), .POS_W(16)) u_dut (
    .clk(clk), .rst(rst), .pulse(pulse), .dir(dir), .start(start), .ack(ack),
    .N(N), .valid(valid), .ovf(ovf), .lost(lost), .pos(pos)
  );

  step_dir_decoder #(.CLK_PER_WIN(CPW), .MIN_HIGH(MH), .POS_W(4)) u_dut_w4 (
    .clk(clk), .rst(rst), .pulse(pulse), .dir(dir), .start(start), .ack(ack),
    .N(N4), .valid(valid4), .ovf(ovf4), .lost(lost4), .pos(pos4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain counters following the window rules.
  int         pos_m   = 0;
  int         net_m   = 0;
  int         win_s   = 0;
  bit         valid_m = 0;
  bit         lost_m  = 0;
  bit         ovf_m   = 0;
  logic [7:0] n_m     = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pack(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 127) m = 127;
    return {(v < 0) ? 1'b1 : 1'b0, 7'(m)};
  endfunction

  function automatic void model_step(input bit d, input bit in_win);
    pos_m += d ? -1 : 1;
    if (in_win) begin
      net_m += d ? -1 : 1;
      if (net_m > 255) net_m = 255;
      if (net_m < -255) net_m = -255;
    end
  endfunction

  function automatic void model_close(input bit ack_same);
    n_m     = pack(net_m);
    ovf_m   = (net_m > 127) || (net_m < -127);
    lost_m  = ack_same ? 1'b0 : (lost_m | valid_m);
    valid_m = 1'b1;
    net_m   = 0;
    win_s  += CPW;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".N"},     {24'b0, N},     {24'b0, n_m});
    check_eq({tag, ".ovf"},   {31'b0, ovf},   {31'b0, ovf_m});
    check_eq({tag, ".valid"}, {31'b0, valid}, {31'b0, valid_m});
    check_eq({tag, ".lost"},  {31'b0, lost},  {31'b0, lost_m});
    check_eq({tag, ".pos"},   {16'b0, pos},   pos_m & 32'hFFFF);
    check_eq({tag, ".pos4"},  {28'b0, pos4},  pos_m & 32'hF);
  endtask

  task automatic step_pulse(input bit d, input int pre, input int hi, input int lo);
    dir = d;
    repeat (pre) tick();
    pulse = 1'b1;
    repeat (hi) tick();
    pulse = 1'b0;
    repeat (lo) tick();
    if (hi >= int'(MH)) model_step(d, 1'b1);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    win_s = cyc;
    net_m = 0;
  endtask

  task automatic wait_close(input string tag);
    while (cyc < win_s + int'(CPW)) tick();
    model_close(1'b0);
    check_all(tag);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    valid_m = 1'b0;
    lost_m  = 1'b0;
    check_eq({tag, ".ack_valid"}, {31'b0, valid}, 32'd0);
    check_eq({tag, ".ack_lost"},  {31'b0, lost},  32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pulse = 1'b0; dir = 1'b0; start = 1'b0; ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    win_s = cyc;
    check_all("reset");

    // Fixed positive count
    do_start();
    repeat (25) step_pulse(1'b0, 0, 8, 32);
    wait_close("pos25");
    do_ack("pos25");

    // Negative count and ack
    do_start();
    step_pulse(1'b1, 3, 8, 32);
    repeat (9) step_pulse(1'b1, 0, 8, 32);
    wait_close("neg10");
    do_ack("neg10");

    // Glitch rejection, then one long high phase
    do_start();
    repeat (10) step_pulse(1'b0, 3, 3, 8);
    step_pulse(1'b0, 0, 40, 8);
    wait_close("glitch");
    do_ack("glitch");

    // Saturation, overrun, ack on close cycle
    do_start();
    repeat (130) step_pulse(1'b0, 0, 4, 2);
    wait_close("sat");
    wait_close("overrun");
    while (cyc < win_s + int'(CPW) - 1) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    model_close(1'b1);
    check_all("ack_on_close");
    do_ack("ack_on_close");

    // Step on the same cycle as start, then step on the closing cycle
    dir = 1'b0;
    repeat (3) tick();
    pulse = 1'b1;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    win_s = cyc;
    net_m = 0;
    model_step(1'b0, 1'b0);
    repeat (2) tick();
    pulse = 1'b0;
    while (cyc < win_s + int'(CPW) - 6) tick();
    pulse = 1'b1;
    repeat (6) tick();
    model_step(1'b0, 1'b1);
    wait_close("simul");
    repeat (2) tick();
    pulse = 1'b0;
    repeat (8) tick();
    do_ack("simul");

    // Reset mid-window
    do_start();
    repeat (5) step_pulse(1'b0, 0, 8, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    win_s = cyc; pos_m = 0; net_m = 0; valid_m = 0; lost_m = 0; ovf_m = 0; n_m = '0;
    check_all("rst_mid");
    wait_close("after_rst");
    do_ack("after_rst");

    // 17 steps: 4-bit position wraps to 1
    do_start();
    repeat (17) step_pulse(1'b0, 0, 4, 4);
    check_eq("wrap.pos4", {28'b0, pos4}, 32'd1);
    check_eq("wrap.pos",  {16'b0, pos},  32'd17);
    wait_close("wrap");
    do_ack("wrap");

    // Randomized windows, mixed direction and widths
    for (int w = 0; w < 5; w++) begin
      do_start();
      while (cyc - win_s < 850)
        step_pulse(1'($urandom_range(0, 1)), 3, int'($urandom_range(1, 8)),
                   int'($urandom_range(4, 10)));
      wait_close("rand");
      do_ack("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
